alu_result_queue: RTL and testbench

Downstream stage of the ALU: captures each ALU result with its zero flag and opcode into a small FIFO. Presents entries to the consumer over a valid/ready handshake. Keeps saturating statistics of accepted and zero results. Flags any result whose zero flag disagrees with the result value.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_result_queue_if.sv | 37 +++
 rtl/alu_rq_fifo.sv | 74 +++++++
 rtl/alu_result_queue.sv | 67 ++++++
 tb/tb_alu_result_queue.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, default widths and the queued result entry.
package alu_pkg;

    localparam int unsigned ALU_DATA_W = 8;
    localparam int unsigned ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_OR      = 4'd3,
        OP_XOR     = 4'd4,
        OP_NOT     = 4'd5,
        OP_SEL_SUM = 4'd6,
        OP_ADD_REV = 4'd7
    } alu_op_e;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] result;
        logic                  zero;
        logic [ALU_OP_W-1:0]   opcode;
    } alu_entry_t;

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer/consumer handshake, flush control and status bundle of the ALU result queue.
interface alu_result_queue_if #(
    parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
    parameter int unsigned OP_W   = alu_pkg::ALU_OP_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) ();

    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_result;
    logic                       in_zero;
    logic [OP_W-1:0]            in_opcode;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_result;
    logic                       out_zero;
    logic [OP_W-1:0]            out_opcode;
    logic                       flush;
    logic [$clog2(DEPTH):0]     level;
    logic [CNT_W-1:0]           total_count;
    logic [CNT_W-1:0]           zero_count;
    logic                       err_zero_mismatch;

    modport master (
        output in_valid, in_result, in_zero, in_opcode, out_ready, flush,
        input  in_ready, out_valid, out_result, out_zero, out_opcode,
        input  level, total_count, zero_count, err_zero_mismatch
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_opcode, out_ready, flush,
        output in_ready, out_valid, out_result, out_zero, out_opcode,
        output level, total_count, zero_count, err_zero_mismatch
    );

endinterface

// File: rtl/alu_rq_fifo.sv
// Result storage: circular buffer with wrapping pointers and an explicit occupancy register.
module alu_rq_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned OP_W   = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [DATA_W-1:0]      wr_result,
    input  logic                   wr_zero,
    input  logic [OP_W-1:0]        wr_opcode,
    output logic [DATA_W-1:0]      head_result,
    output logic                   head_zero,
    output logic [OP_W-1:0]        head_opcode,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [OP_W-1:0]   opcode;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign head_result = mem[rd_ptr].result;
    assign head_zero   = mem[rd_ptr].zero;
    assign head_opcode = mem[rd_ptr].opcode;

    // Storage is cleared on reset so the head outputs never show X, but kept on flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{result: wr_result, zero: wr_zero, opcode: wr_opcode};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_queue.sv
// ALU result queue: handshake wrapper around the FIFO with saturating statistics and zero-flag check.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = ALU_DATA_W,
    parameter int unsigned OP_W   = ALU_OP_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_result_queue_if.slave q
);

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic counted;

    // in_ready depends only on registered occupancy: no pass-through when full.
    assign q.in_ready  = !full;
    assign q.out_valid = !empty;
    assign push        = q.in_valid && !full;
    assign pop         = !empty && q.out_ready;
    assign counted     = push && !q.flush;

    alu_rq_fifo #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .pop         (pop),
        .flush       (q.flush),
        .wr_result   (q.in_result),
        .wr_zero     (q.in_zero),
        .wr_opcode   (q.in_opcode),
        .head_result (q.out_result),
        .head_zero   (q.out_zero),
        .head_opcode (q.out_opcode),
        .level       (q.level),
        .full        (full),
        .empty       (empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q.total_count       <= '0;
            q.zero_count        <= '0;
            q.err_zero_mismatch <= 1'b0;
        end else if (counted) begin
            if (q.total_count != '1) begin
                q.total_count <= q.total_count + CNT_W'(1);
            end
            if (q.in_zero && (q.zero_count != '1)) begin
                q.zero_count <= q.zero_count + CNT_W'(1);
            end
            if (q.in_zero != (q.in_result == '0)) begin
                q.err_zero_mismatch <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized bench for alu_result_queue against a queue-based reference model (CNT_W=16 and CNT_W=4 copies).
module tb_alu_result_queue;
    import alu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_queue_if #(.DATA_W(8), .OP_W(4), .DEPTH(DEPTH), .CNT_W(16)) q ();
    alu_result_queue_if #(.DATA_W(8), .OP_W(4), .DEPTH(DEPTH), .CNT_W(4))  q4 ();

    alu_result_queue #(.DATA_W(8), .OP_W(4), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q)
    );

    alu_result_queue #(.DATA_W(8), .OP_W(4), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q4)
    );

    assign q4.in_valid  = q.in_valid;
    assign q4.in_result = q.in_result;
    assign q4.in_zero   = q.in_zero;
    assign q4.in_opcode = q.in_opcode;
    assign q4.out_ready = q.out_ready;
    assign q4.flush     = q.flush;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    alu_entry_t  m_q[$];
    int unsigned m_total = 0;
    int unsigned m_zero  = 0;
    bit          m_err   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic set_in(input bit v, input logic [7:0] r, input bit z, input logic [3:0] op);
        q.in_valid  = v;
        q.in_result = r;
        q.in_zero   = z;
        q.in_opcode = op;
    endtask

    task automatic set_rand_in(input bit v, input bit allow_bad);
        logic [7:0] r;
        bit         z;
        r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        z = (r == 8'h00);
        if (allow_bad && $urandom_range(0, 31) == 0) z = !z;
        set_in(v, r, z, 4'($urandom));
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model on the edge.
    task automatic step();
        alu_entry_t e;
        bit         dp;
        bit         dpop;
        @(negedge clk);
        check_eq("level", 32'(q.level), m_q.size());
        check_eq("in_ready", 32'(q.in_ready), 32'(m_q.size() != DEPTH));
        check_eq("out_valid", 32'(q.out_valid), 32'(m_q.size() != 0));
        check_eq("total_count", 32'(q.total_count), sat(m_total, 65535));
        check_eq("zero_count", 32'(q.zero_count), sat(m_zero, 65535));
        check_eq("err_zero_mismatch", 32'(q.err_zero_mismatch), 32'(m_err));
        check_eq("total_count_w4", 32'(q4.total_count), sat(m_total, 15));
        check_eq("zero_count_w4", 32'(q4.zero_count), sat(m_zero, 15));
        if (m_q.size() != 0) begin
            check_eq("out_result", 32'(q.out_result), 32'(m_q[0].result));
            check_eq("out_zero", 32'(q.out_zero), 32'(m_q[0].zero));
            check_eq("out_opcode", 32'(q.out_opcode), 32'(m_q[0].opcode));
        end
        dp   = q.in_valid && (m_q.size() != DEPTH);
        dpop = (m_q.size() != 0) && q.out_ready;
        e    = '{result: q.in_result, zero: q.in_zero, opcode: q.in_opcode};
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_total = 0;
            m_zero  = 0;
            m_err   = 1'b0;
        end else if (q.flush) begin
            m_q.delete();
        end else begin
            if (dpop) void'(m_q.pop_front());
            if (dp) begin
                m_q.push_back(e);
                m_total++;
                if (e.zero) m_zero++;
                if (e.zero != (e.result == 8'h00)) m_err = 1'b1;
            end
        end
        #1;
    endtask

    task automatic drain();
        int unsigned n = 0;
        q.in_valid  = 1'b0;
        q.out_ready = 1'b1;
        while (m_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check_eq("drain_level", 32'(q.level), 32'd0);
    endtask

    alu_entry_t  tbl [4];
    int unsigned t_before;

    initial begin
        tbl[0] = '{result: 8'h12, zero: 1'b0, opcode: OP_ADD};
        tbl[1] = '{result: 8'h00, zero: 1'b1, opcode: OP_SUB};
        tbl[2] = '{result: 8'hFF, zero: 1'b0, opcode: OP_NOT};
        tbl[3] = '{result: 8'h00, zero: 1'b1, opcode: OP_AND};

        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        q.out_ready = 1'b0;
        q.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_level", 32'(q.level), 32'd0);
        check_eq("rst_in_ready", 32'(q.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(q.out_valid), 32'd0);
        check_eq("rst_out_result", 32'(q.out_result), 32'd0);
        check_eq("rst_out_zero", 32'(q.out_zero), 32'd0);
        check_eq("rst_out_opcode", 32'(q.out_opcode), 32'd0);
        check_eq("rst_total", 32'(q.total_count), 32'd0);
        check_eq("rst_err", 32'(q.err_zero_mismatch), 32'd0);
        rst_n = 1'b1;

        // Fill with the directed table while the consumer stalls, then drain in order.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, tbl[i].result, tbl[i].zero, tbl[i].opcode);
            step();
        end
        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        check_eq("fill_level", 32'(q.level), 32'd4);
        check_eq("fill_in_ready", 32'(q.in_ready), 32'd0);
        check_eq("fill_total", 32'(q.total_count), 32'd4);
        check_eq("fill_zero", 32'(q.zero_count), 32'd2);
        check_eq("fill_head", 32'(q.out_result), 32'h12);
        drain();

        // Steady streaming at level 2.
        q.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand_in(1'b1, 1'b0);
            step();
        end
        q.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_rand_in(1'b1, 1'b0);
            step();
            check_eq("steady_level", 32'(q.level), 32'd2);
        end
        drain();

        // Sticky mismatch flag survives flush.
        q.out_ready = 1'b0;
        set_in(1'b1, 8'h05, 1'b1, OP_ADD);
        step();
        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        check_eq("mismatch_set", 32'(q.err_zero_mismatch), 32'd1);
        q.flush = 1'b1;
        step();
        q.flush = 1'b0;
        step();
        check_eq("mismatch_after_flush", 32'(q.err_zero_mismatch), 32'd1);

        // Flush at level 3 with concurrent push and pop.
        for (int i = 0; i < 3; i++) begin
            set_rand_in(1'b1, 1'b0);
            step();
        end
        check_eq("pre_flush_level", 32'(q.level), 32'd3);
        t_before = m_total;
        set_rand_in(1'b1, 1'b0);
        q.out_ready = 1'b1;
        q.flush     = 1'b1;
        step();
        q.flush = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        check_eq("flush_level", 32'(q.level), 32'd0);
        check_eq("flush_out_valid", 32'(q.out_valid), 32'd0);
        check_eq("flush_total", 32'(q.total_count), t_before);

        // Twenty more pushes: the 4-bit counters must sit at 15.
        for (int i = 0; i < 20; i++) begin
            set_rand_in(1'b1, 1'b0);
            step();
        end
        check_eq("sat_total_w4", 32'(q4.total_count), 32'd15);
        drain();

        // Random traffic with occasional flushes and bad zero flags.
        for (int i = 0; i < 300; i++) begin
            set_rand_in($urandom_range(0, 3) != 0, 1'b1);
            q.out_ready = ($urandom_range(0, 1) == 1);
            q.flush     = ($urandom_range(0, 15) == 0);
            step();
        end
        q.flush = 1'b0;
        drain();

        // Reset on a full queue with push and pop requested.
        q.out_ready = 1'b0;
        for (int i = 0; i < 8 && m_q.size() < DEPTH; i++) begin
            set_rand_in(1'b1, 1'b0);
            step();
        end
        check_eq("full_before_rst", 32'(q.level), 32'd4);
        set_rand_in(1'b1, 1'b0);
        q.out_ready = 1'b1;
        rst_n       = 1'b0;
        step();
        rst_n = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        check_eq("rst2_level", 32'(q.level), 32'd0);
        check_eq("rst2_in_ready", 32'(q.in_ready), 32'd1);
        check_eq("rst2_out_valid", 32'(q.out_valid), 32'd0);
        check_eq("rst2_out_result", 32'(q.out_result), 32'd0);
        check_eq("rst2_total", 32'(q.total_count), 32'd0);
        check_eq("rst2_zero", 32'(q.zero_count), 32'd0);
        check_eq("rst2_total_w4", 32'(q4.total_count), 32'd0);
        check_eq("rst2_err", 32'(q.err_zero_mismatch), 32'd0);
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
